heartbeat_tx_scheduler: RTL

HEARTBEAT_TX_SCHEDULER -- requirements
Module: heartbeat_tx_scheduler

---
 rtl/hb_pkg.sv | 22 ++
 rtl/interval_timer.sv | 28 ++
 rtl/heartbeat_tx_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hb_pkg.sv
// Shared types and default widths for the heartbeat transmit scheduler.
// Holds the FSM state enumeration and the statistics saturation helper.
package hb_pkg;

  localparam int DEF_SEQ_W   = 8;
  localparam int DEF_RETRY_W = 4;
  localparam int STAT_W      = 16;
  localparam int CNT_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PERIOD,
    ST_SEND,
    ST_WAIT_ACK,
    ST_FAULT
  } hb_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Saturating cycle counter with a synchronous clear and a >= limit compare.
// Clear has priority over enable; the count never wraps past all-ones.
module interval_timer
  import hb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

  assign expired = (count >= limit);

endmodule

// File: rtl/heartbeat_tx_scheduler.sv
// Heartbeat scheduler: periodic send, ack wait with bounded retries, sticky fault.
// Optional statistics counters are built only when HB_STATS_EN is defined.
module heartbeat_tx_scheduler
  import hb_pkg::*;
#(
  parameter int SEQ_W   = DEF_SEQ_W,
  parameter int RETRY_W = DEF_RETRY_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [31:0]        period,
  input  logic [31:0]        ack_limit,
  input  logic [RETRY_W-1:0] max_retry,
  output logic               hb_valid,
  input  logic               hb_ready,
  output logic [SEQ_W-1:0]   hb_seq,
  input  logic               hb_ack,
  output logic               fault,
  output logic               busy,
  output logic [STAT_W-1:0]  hb_sent_cnt,
  output logic [STAT_W-1:0]  hb_timeout_cnt,
  output hb_state_e          dbg_state
);

  hb_state_e          state, next_state;
  logic [RETRY_W-1:0] rcnt, rcnt_nxt;
  logic               seq_inc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   tmr_limit;
  logic               expired;
  logic               hs;

  // hb_valid/hb_ready: once hb_valid rises, it and hb_seq hold until a cycle
  // with both high; that cycle is the single transfer and valid drops after it.
  assign hs = hb_valid && hb_ready;

  assign tmr_limit = (state == ST_WAIT_ACK) ? ack_limit : period;

  interval_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (next_state != state),
    .enable  ((state == ST_WAIT_PERIOD) || (state == ST_WAIT_ACK)),
    .limit   (tmr_limit),
    .count   (cnt),
    .expired (expired)
  );

  always_comb begin
    next_state = state;
    rcnt_nxt   = rcnt;
    seq_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          next_state = ST_WAIT_PERIOD;
          rcnt_nxt   = '0;
        end
      end
      ST_WAIT_PERIOD: begin
        if (!enable)      next_state = ST_IDLE;
        else if (expired) next_state = ST_SEND;
      end
      ST_SEND: begin
        if (hs) next_state = enable ? ST_WAIT_ACK : ST_IDLE;
      end
      ST_WAIT_ACK: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (hb_ack) begin
          // an ack arriving on the timeout cycle still counts as an ack
          next_state = ST_WAIT_PERIOD;
          rcnt_nxt   = '0;
          seq_inc    = 1'b1;
        end else if (expired) begin
          if (rcnt == max_retry) begin
            next_state = ST_FAULT;
          end else begin
            next_state = ST_SEND;
            rcnt_nxt   = rcnt + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (!enable) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rcnt     <= '0;
      hb_seq   <= '0;
      hb_valid <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= next_state;
      rcnt     <= rcnt_nxt;
      hb_valid <= (next_state == ST_SEND);
      fault    <= (next_state == ST_FAULT);
      if (seq_inc) hb_seq <= hb_seq + 1'b1;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

`ifdef HB_STATS_EN
  logic timeout_hit;
  assign timeout_hit = (state == ST_WAIT_ACK) && enable && !hb_ack && expired;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hb_sent_cnt    <= '0;
      hb_timeout_cnt <= '0;
    end else begin
      if (hs)          hb_sent_cnt    <= sat_inc(hb_sent_cnt);
      if (timeout_hit) hb_timeout_cnt <= sat_inc(hb_timeout_cnt);
    end
  end
`else
  assign hb_sent_cnt    = '0;
  assign hb_timeout_cnt = '0;
`endif

endmodule
